// File: rtl/trivium_byte_xor_pkg.sv
// Shared constants for the trivium keystream byte-XOR block: word width,
// default warm-up length and FSM state encodings.
package trivium_pkg;

  localparam int DATA_W            = 8;
  localparam int WARMUP_CYCLES_DEF = 1152;

  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Counter width that never collapses to zero bits for tiny warm-up values.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trivium_byte_xor_if.sv
// Byte stream bundle: upstream s_* channel and downstream m_* channel,
// both valid/ready.
interface trivium_byte_xor_if;
  import trivium_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );
endinterface

// File: rtl/trivium_byte_xor_ks_packer.sv
// Packs keystream bits MSB-first into key bytes and drives the core enable.
// TRIVIUM_KS_PREFETCH_EN: the shift register acts as a second key buffer.
module trivium_ks_packer
  import trivium_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              active_i,
  input  logic              ks_bit_i,
  input  logic              consume_i,
  output logic              fill_en_o,
  output logic              key_valid_o,
  output logic              key_valid_next_o,
  output logic [DATA_W-1:0] key_o
);
  localparam int BCW = cnt_width(DATA_W);

  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic [DATA_W-1:0] shift_new;
  logic              byte_done;
`ifdef TRIVIUM_KS_PREFETCH_EN
  logic              shift_full_q, shift_full_d;

  assign fill_en_o = active_i && !(key_valid_q && shift_full_q);
`else
  assign fill_en_o = active_i && !key_valid_q;
`endif

  assign shift_new = {shift_q[DATA_W-2:0], ks_bit_i};
  assign byte_done = fill_en_o && (bit_cnt_q == BCW'(DATA_W - 1));

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
`ifdef TRIVIUM_KS_PREFETCH_EN
    shift_full_d = shift_full_q;
`endif
    if (fill_en_o) begin
      shift_d   = shift_new;
      bit_cnt_d = byte_done ? '0 : bit_cnt_q + 1'b1;
    end
`ifdef TRIVIUM_KS_PREFETCH_EN
    // A completed byte parked in the shift register moves up when the key is used.
    if (consume_i) begin
      if (shift_full_q) begin
        key_d        = shift_q;
        shift_full_d = 1'b0;
      end else begin
        key_valid_d = 1'b0;
      end
    end
    if (byte_done) begin
      if (!key_valid_q || consume_i) begin
        key_d       = shift_new;
        key_valid_d = 1'b1;
      end else begin
        shift_full_d = 1'b1;
      end
    end
`else
    if (consume_i) key_valid_d = 1'b0;
    if (byte_done) begin
      key_d       = shift_new;
      key_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
`ifdef TRIVIUM_KS_PREFETCH_EN
      shift_full_q <= 1'b0;
`endif
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
`ifdef TRIVIUM_KS_PREFETCH_EN
      shift_full_q <= shift_full_d;
`endif
    end
  end

  assign key_valid_o      = key_valid_q;
  assign key_valid_next_o = key_valid_d;
  assign key_o            = key_q;
endmodule

// File: rtl/trivium_byte_xor.sv
// Trivium keystream consumer: discards warm-up, XORs key bytes onto a byte stream.
// Optional macro TRIVIUM_KS_PREFETCH_EN enables a second key-byte buffer.
module trivium_byte_xor
  import trivium_pkg::*;
#(
  parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic ks_en,
  input  logic ks_bit,
  output logic warm_done,
  trivium_byte_xor_if.slave bus
);
  localparam int WCW = cnt_width(WARMUP_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [WCW-1:0]    warm_cnt_q, warm_cnt_d;
  logic              warm_done_q, warm_done_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              fill_en, key_valid, key_valid_next;
  logic [DATA_W-1:0] key;
  logic              s_ready, xfer;

  trivium_ks_packer u_packer (
    .clk             (clk),
    .rst             (rst),
    .active_i        (state_q != ST_WARMUP),
    .ks_bit_i        (ks_bit),
    .consume_i       (xfer),
    .fill_en_o       (fill_en),
    .key_valid_o     (key_valid),
    .key_valid_next_o(key_valid_next),
    .key_o           (key)
  );

  // Gated by rst so the core is held still while reset is asserted.
  assign ks_en   = !rst && ((state_q == ST_WARMUP) || fill_en);
  assign s_ready = key_valid && (!m_valid_q || bus.m_ready);
  assign xfer    = bus.s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    warm_done_d = warm_done_q;
    case (state_q)
      ST_WARMUP: begin
        if (warm_cnt_q == WCW'(WARMUP_CYCLES - 1)) begin
          warm_cnt_d  = '0;
          warm_done_d = 1'b1;
          state_d     = ST_FILL;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      ST_FILL, ST_HOLD: state_d = key_valid_next ? ST_HOLD : ST_FILL;
      default:          state_d = ST_WARMUP;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (xfer) begin
      m_data_d  = bus.s_data ^ key;
      m_valid_d = 1'b1;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WARMUP;
      warm_cnt_q  <= '0;
      warm_done_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      warm_done_q <= warm_done_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
    end
  end

  assign warm_done   = warm_done_q;
  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
endmodule

// File: tb/tb_trivium_byte_xor.sv
// Bench for trivium_byte_xor: behavioural trivium core plus a golden bit array,
// scoreboard over randomized valid/ready traffic, and directed reset/stub checks.
module tb_trivium_byte_xor;
  localparam int WARM  = 1152;
  localparam int NREF  = WARM + 8 * 64;
`ifdef TRIVIUM_KS_PREFETCH_EN
  localparam int PERIOD    = 8;
  localparam int HOLD_KSEN = 1;
`else
  localparam int PERIOD    = 9;
  localparam int HOLD_KSEN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ks_en, ks_bit, warm_done;
  trivium_byte_xor_if bus();

  trivium_byte_xor #(.WARMUP_CYCLES(WARM)) dut (
    .clk(clk), .rst(rst), .ks_en(ks_en), .ks_bit(ks_bit),
    .warm_done(warm_done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_errors = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural trivium (standard state s1..s288).
  logic [1:80] key_v, iv_v;

  function automatic logic trv_z(input logic [1:288] s);
    return s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
  endfunction

  function automatic logic [1:288] trv_next(input logic [1:288] s);
    logic t1, t2, t3;
    logic [1:288] n;
    t1 = s[66] ^ s[93] ^ (s[91] & s[92]) ^ s[171];
    t2 = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
    t3 = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
    n[1] = t3;   n[2:93]    = s[1:92];
    n[94] = t1;  n[95:177]  = s[94:176];
    n[178] = t2; n[179:288] = s[178:287];
    return n;
  endfunction

  function automatic logic [1:288] trv_init();
    logic [1:288] n;
    n = '0;
    n[1:80]   = key_v;
    n[94:173] = iv_v;
    n[286] = 1'b1; n[287] = 1'b1; n[288] = 1'b1;
    return n;
  endfunction

  // Core stand-in: real trivium, or a stub repeating 0xB2 MSB-first after warm-up.
  logic [1:288] core_s;
  int           stub_cnt;
  logic         stub_mode = 1'b0;
  logic [7:0]   stub_pat  = 8'hB2;
  logic [2:0]   stub_idx;

  always @(posedge clk) begin
    if (rst) begin
      core_s   <= trv_init();
      stub_cnt <= 0;
    end else if (ks_en) begin
      core_s   <= trv_next(core_s);
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign stub_idx = 3'd7 - 3'(stub_cnt);
  assign ks_bit   = stub_mode ? stub_pat[stub_idx] : trv_z(core_s);

  logic ref_bits [0:NREF-1];
  int   key_idx;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] sb_q[$];

  function automatic logic [7:0] exp_byte(input int idx);
    logic [7:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) v = {v[6:0], ref_bits[WARM + 8 * idx + b]};
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ks_en"},     ks_en,       0);
    check({tag, "_s_ready"},   bus.s_ready, 0);
    check({tag, "_m_valid"},   bus.m_valid, 0);
    check({tag, "_m_data"},    bus.m_data,  0);
    check({tag, "_warm_done"}, warm_done,   0);
  endtask

  // Reset, then walk the warm-up window; returns in the first post-warm-up cycle.
  task automatic reset_and_warmup();
    rst = 1'b1; bus.s_valid = 1'b0; bus.m_ready = 1'b0; bus.s_data = '0;
    key_idx = 0;
    @(negedge clk); @(negedge clk);
    #1 check_reset_outputs("rst");
    rst = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'($urandom);
    for (int k = 0; k < WARM; k++) begin
      #1;
      check("warm_ks_en", ks_en, 1);
      check("warm_done_low", warm_done, 0);
      check("warm_s_ready", bus.s_ready, 0);
      @(negedge clk);
    end
    #1 check("warm_done_rise", warm_done, 1);
    bus.s_valid = 1'b0;
  endtask

  // mode 0: always valid/ready; 1: random handshakes; 2: 20-clk m_ready stall.
  task automatic run_stream(input int nbytes, input int mode);
    int sent, recv, cyc, last_x;
    logic xfer, prev_xfer, prev_hold;
    logic [7:0] prev_data;
    sent = 0; recv = 0; cyc = 0; last_x = -1;
    prev_xfer = 1'b0; prev_hold = 1'b0; prev_data = '0;
    sb_q.delete(); rx_q.delete();
    while (recv < nbytes && cyc < nbytes * 40 + 100) begin
      bus.s_valid = (sent < nbytes) && (mode != 1 || $urandom_range(0, 3) != 0);
      bus.s_data  = (sent < nbytes) ? tx_q[sent] : 8'($urandom);
      case (mode)
        1:       bus.m_ready = ($urandom_range(0, 2) != 0);
        2:       bus.m_ready = !(cyc >= 9 && cyc < 29);
        default: bus.m_ready = 1'b1;
      endcase
      #1;
      if (prev_xfer) check("latency_m_valid", bus.m_valid, 1);
      if (prev_hold) begin
        check("hold_m_valid", bus.m_valid, 1);
        check("hold_m_data", bus.m_data, prev_data);
      end
      if (bus.s_ready) check("s_ready_rule", bus.m_valid && !bus.m_ready, 0);
      if (mode == 2 && cyc == 28) begin
        check("stall_ks_en", ks_en, 0);
        check("stall_s_ready", bus.s_ready, 0);
        check("stall_m_valid", bus.m_valid, 1);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (sb_q.size() == 0) check("spurious_m_valid", 1, 0);
        else check("m_data", bus.m_data, sb_q.pop_front());
        $display("txn %0d: m_data=%02h", recv, bus.m_data);
        rx_q.push_back(bus.m_data);
        recv++;
      end
      xfer = bus.s_valid && bus.s_ready;
      if (xfer) begin
        sb_q.push_back(bus.s_data ^ exp_byte(key_idx));
        key_idx++;
        sent++;
        if (mode == 0 && last_x >= 0) check("byte_period", cyc - last_x, PERIOD);
        last_x = cyc;
      end
      prev_xfer = xfer;
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
      @(negedge clk);
      cyc++;
    end
    if (recv != nbytes) check("stream_timeout", recv, nbytes);
    bus.s_valid = 1'b0;
  endtask

  task automatic zeros(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'h00);
  endtask

  initial begin
    logic [95:0] r;
    logic [1:288] s;
    logic [7:0] cipher[$];
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    r = {$urandom, $urandom, $urandom}; key_v = r[79:0];
    r = {$urandom, $urandom, $urandom}; iv_v  = r[79:0];
    s = trv_init();
    for (int i = 0; i < NREF; i++) begin
      ref_bits[i] = trv_z(s);
      s = trv_next(s);
    end

    // Warm-up window and stub packing: key 0xB2, 0xFF -> 0x4D.
    stub_mode = 1'b1;
    reset_and_warmup();
    bus.s_valid = 1'b1; bus.s_data = 8'hFF; bus.m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fill_s_ready", bus.s_ready, 0);
      check("fill_ks_en", ks_en, 1);
      @(negedge clk);
    end
    #1;
    check("key_s_ready", bus.s_ready, 1);
    check("hold_ks_en", ks_en, HOLD_KSEN);
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
    check("stub_m_valid", bus.m_valid, 1);
    check("stub_m_data", bus.m_data, 8'h4D);
    stub_mode = 1'b0;

    // Real-core vector, 10 zero bytes.
    reset_and_warmup();
    zeros(10);
    run_stream(10, 0);

    // Backpressure stall and recovery.
    reset_and_warmup();
    tx_q.delete();
    for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom));
    run_stream(5, 2);

    // Random data and handshakes.
    reset_and_warmup();
    tx_q.delete();
    for (int i = 0; i < 30; i++) tx_q.push_back(8'($urandom));
    run_stream(30, 1);

    // Round trip: encrypt, reset, decrypt.
    reset_and_warmup();
    tx_q.delete(); tx_q.push_back(8'h48); tx_q.push_back(8'h69);
    run_stream(2, 0);
    cipher = rx_q;
    reset_and_warmup();
    tx_q = cipher;
    run_stream(2, 1);
    check("roundtrip_0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h48);
    check("roundtrip_1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h69);

    // Reset four bits into FILL.
    reset_and_warmup();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("midfill");
    reset_and_warmup();
    zeros(10);
    run_stream(10, 0);

    // Reset with an output byte pending.
    reset_and_warmup();
    bus.s_valid = 1'b1; bus.s_data = 8'($urandom); bus.m_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1 check("pending_m_valid", bus.m_valid, 1);
    rst = 1'b1;
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1 check_reset_outputs("pending");
    reset_and_warmup();
    zeros(10);
    run_stream(10, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
